ro_puf_ctrl: RTL and testbench



---
 rtl/ro_puf_pkg.sv | 36 +++
 rtl/ro_puf_window_timer.sv | 28 ++
 rtl/ro_puf_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF controller.
// Holds the sequencer state encoding and the challenge select extractor.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam int SEL_W_DEF      = 4;
  localparam int CNT_W_DEF      = 4;
  localparam int NUM_BITS_DEF   = 8;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int WINDOW_CYC_DEF = 64;

  // Upper bounds for the generic extractor; challenges are zero-extended to CHAL_MAX_W.
  localparam int CHAL_MAX_W = 1024;
  localparam int CHAL_IDX_W = $clog2(CHAL_MAX_W);
  localparam int SEL_MAX_W  = 16;

  // Returns select slot 'slot' (sel0 of pair i is slot 2i, sel1 is slot 2i+1).
  function automatic logic [SEL_MAX_W-1:0] sel_extract(input logic [CHAL_MAX_W-1:0] chal,
                                                       input int slot,
                                                       input int sel_w);
    logic [SEL_MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < SEL_MAX_W; b++) begin
      if (b < sel_w) r[b] = chal[CHAL_IDX_W'(slot * sel_w + b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_puf_window_timer.sv
// Loadable down-counter shared by the SETTLE and MEASURE intervals.
// expire_o is high in the last cycle of a loaded interval.
module ro_puf_window_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expire_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)              count_d = value_i;
    else if (count_q != '0)  count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF sequencer: per challenge pair settle, count, compare into one response bit.
// Optional RO_PUF_CTRL_TIE_MASK_EN adds a tie_mask output flagging equal counts per bit.
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int SEL_W      = SEL_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NUM_BITS   = NUM_BITS_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WINDOW_CYC = WINDOW_CYC_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [2*NUM_BITS*SEL_W-1:0] challenge,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_BITS-1:0]         response,
  output logic                        err,
  output logic [SEL_W-1:0]            sel0,
  output logic [SEL_W-1:0]            sel1,
  output logic                        cnt_clr,
  output logic                        cnt_en,
  input  logic [CNT_W-1:0]            cnt0,
  input  logic [CNT_W-1:0]            cnt1
`ifdef RO_PUF_CTRL_TIE_MASK_EN
  ,
  output logic [NUM_BITS-1:0]         tie_mask
`endif
);

  localparam int CHAL_W  = 2 * NUM_BITS * SEL_W;
  localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

  state_e               state_q;
  logic [CHAL_W-1:0]    chal_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 busy_q, done_q, err_q, cnt_clr_q, cnt_en_q;
  logic [NUM_BITS-1:0]  response_q;
  logic [SEL_W-1:0]     sel0_q, sel1_q;

  logic                 tmr_load, tmr_expire, last_pair;
  logic [TMR_W-1:0]     tmr_value;
  logic [SEL_W-1:0]     first_sel0_d, first_sel1_d, next_sel0_d, next_sel1_d;

  assign last_pair = (idx_q == LAST_IDX);

  // Pair 0 comes straight from the port so its selects are valid in the first SETTLE cycle.
  assign first_sel0_d = SEL_W'(sel_extract(CHAL_MAX_W'(challenge), 0, SEL_W));
  assign first_sel1_d = SEL_W'(sel_extract(CHAL_MAX_W'(challenge), 1, SEL_W));
  assign next_sel0_d  = SEL_W'(sel_extract(CHAL_MAX_W'(chal_q), 2 * (int'(idx_q) + 1), SEL_W));
  assign next_sel1_d  = SEL_W'(sel_extract(CHAL_MAX_W'(chal_q), 2 * (int'(idx_q) + 1) + 1, SEL_W));

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = TMR_W'(SETTLE_CYC);
    case (state_q)
      ST_IDLE:    tmr_load = start;
      ST_SETTLE: begin
        tmr_load  = tmr_expire;
        tmr_value = TMR_W'(WINDOW_CYC);
      end
      ST_COMPARE: tmr_load = !last_pair;
      default:    tmr_load = 1'b0;
    endcase
  end

  ro_puf_window_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      chal_q     <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      response_q <= '0;
      sel0_q     <= '0;
      sel1_q     <= '0;
      cnt_clr_q  <= 1'b1;
      cnt_en_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_clr_q <= 1'b1;
          cnt_en_q  <= 1'b0;
          if (start) begin
            chal_q     <= challenge;
            response_q <= '0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            sel0_q     <= first_sel0_d;
            sel1_q     <= first_sel1_d;
            busy_q     <= 1'b1;
            state_q    <= ST_SETTLE;
          end
        end
        ST_SETTLE: if (tmr_expire) begin
          cnt_clr_q <= 1'b0;
          cnt_en_q  <= 1'b1;
          state_q   <= ST_MEASURE;
        end
        // Counters stay un-cleared through COMPARE so the sampled counts are frozen.
        ST_MEASURE: if (tmr_expire) begin
          cnt_en_q <= 1'b0;
          state_q  <= ST_COMPARE;
        end
        ST_COMPARE: begin
          response_q[idx_q] <= (cnt0 > cnt1);
          if (sel0_q == sel1_q) err_q <= 1'b1;
          cnt_clr_q <= 1'b1;
          if (!last_pair) begin
            idx_q   <= idx_q + IDX_W'(1);
            sel0_q  <= next_sel0_d;
            sel1_q  <= next_sel1_d;
            state_q <= ST_SETTLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          cnt_clr_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef RO_PUF_CTRL_TIE_MASK_EN
  logic [NUM_BITS-1:0] tie_mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            tie_mask_q <= '0;
    else if (state_q == ST_IDLE && start) tie_mask_q <= '0;
    else if (state_q == ST_COMPARE)       tie_mask_q[idx_q] <= (cnt0 == cnt1);
  end

  assign tie_mask = tie_mask_q;
`else
  // Ties simply resolve to a 0 response bit; nothing further is tracked.
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign response = response_q;
  assign sel0     = sel0_q;
  assign sel1     = sel1_q;
  assign cnt_clr  = cnt_clr_q;
  assign cnt_en   = cnt_en_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Directed bench for ro_puf_ctrl: a per-RO count table stands in for the counter datapath.
// Define RO_PUF_CTRL_TIE_MASK_EN on both files to also check tie_mask.
module tb_ro_puf_ctrl;

  localparam int SEL_W    = 4;
  localparam int CNT_W    = 4;
  localparam int NUM_BITS = 8;
  localparam int DONE_AT  = 553;

  localparam logic [63:0] CH_ALL   = 64'h8C8C8C8C8C8C8C8C;  // every pair sel0=12 sel1=8
  localparam logic [63:0] CH_P3    = 64'h8C8C8C8C438C8C8C;  // pair 3 sel0=3 sel1=4
  localparam logic [63:0] CH_P0TIE = 64'h8C8C8C8C8C8C8C55;  // pair 0 sel0=sel1=5
  localparam logic [63:0] CH_P7    = 64'hC88C8C8C8C8C8C8C;  // pair 7 sel0=8 sel1=12
  localparam logic [63:0] CH_ALT   = 64'hC8C8C8C8C8C8C8C8;  // all pairs reversed

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [2*NUM_BITS*SEL_W-1:0] challenge;
  logic                        busy, done, err, cnt_clr, cnt_en;
  logic [NUM_BITS-1:0]         response;
  logic [SEL_W-1:0]            sel0, sel1;
  logic [CNT_W-1:0]            cnt0, cnt1;
`ifdef RO_PUF_CTRL_TIE_MASK_EN
  logic [NUM_BITS-1:0]         tie_mask;
`endif

  logic [CNT_W-1:0] ro_cnt [16];
  assign cnt0 = ro_cnt[sel0];
  assign cnt1 = ro_cnt[sel1];

  always #5 clk = ~clk;

  ro_puf_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .challenge (challenge),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .err       (err),
    .sel0      (sel0),
    .sel1      (sel1),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`ifdef RO_PUF_CTRL_TIE_MASK_EN
    ,
    .tie_mask  (tie_mask)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Window/settle/select-timing monitor, active only while busy.
  int               en_run = 0, clr_run = 0;
  logic             en_prev = 1'b0, clr_prev = 1'b0, busy_prev = 1'b0;
  logic [SEL_W-1:0] sel0_prev = '0, sel1_prev = '0;

  always @(negedge clk) begin
    if (!busy) begin
      en_run  = 0;
      clr_run = 0;
    end else begin
      check_eq("clr_en_excl", 64'(cnt_clr & cnt_en), 64'd0);
      if (cnt_en) en_run++;
      if (cnt_en && !en_prev) begin
        check_eq("settle_len", 64'(clr_run), 64'd4);
        clr_run = 0;
      end
      if (!cnt_en && en_prev) begin
        check_eq("window_len", 64'(en_run), 64'd64);
        en_run = 0;
      end
      if (cnt_clr) clr_run++;
      if (busy_prev && (sel0 != sel0_prev || sel1 != sel1_prev))
        check_eq("sel_edge", 64'({en_prev, clr_prev}), 64'd0);
    end
    en_prev   = cnt_en;
    clr_prev  = cnt_clr;
    busy_prev = busy;
    sel0_prev = sel0;
    sel1_prev = sel1;
  end

  task automatic run_chal(input string tag, input logic [63:0] chal, input logic [7:0] exp_resp,
                          input logic exp_err, input logic [7:0] exp_tie, input int disturb_at);
    int               first_done = 0;
    int               pulses     = 0;
    logic             busy_at_done = 1'b1;
    logic             err_at_done  = 1'b0;
    logic [7:0]       resp_at_done = '0;
    @(negedge clk);
    start     = 1'b1;
    challenge = chal;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    challenge = '0;
    check_eq({tag, "_busy_rise"}, 64'(busy), 64'd1);
    check_eq({tag, "_resp_clr"}, 64'(response), 64'd0);
    for (int n = 1; n <= DONE_AT + 7; n++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first_done == 0) begin
          first_done   = n;
          busy_at_done = busy;
          err_at_done  = err;
          resp_at_done = response;
        end
      end
      if (disturb_at != 0 && n == disturb_at) begin
        start     = 1'b1;
        challenge = CH_ALT;
      end
      if (disturb_at != 0 && n == disturb_at + 1) begin
        start     = 1'b0;
        challenge = '0;
      end
    end
    check_eq({tag, "_done_cyc"}, 64'(first_done), 64'(DONE_AT));
    check_eq({tag, "_done_pulses"}, 64'(pulses), 64'd1);
    check_eq({tag, "_resp"}, 64'(resp_at_done), 64'(exp_resp));
    check_eq({tag, "_err"}, 64'(err_at_done), 64'(exp_err));
    check_eq({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    check_eq({tag, "_resp_held"}, 64'(response), 64'(exp_resp));
`ifdef RO_PUF_CTRL_TIE_MASK_EN
    check_eq({tag, "_tie_mask"}, 64'(tie_mask), 64'(exp_tie));
`endif
    $display("run %s resp=%0h err=%0b done_at=%0d pulses=%0d exp_tie=%0h",
             tag, resp_at_done, err_at_done, first_done, pulses, exp_tie);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ro_cnt[i] = '0;
    ro_cnt[12] = 4'd9;
    ro_cnt[8]  = 4'd5;
    ro_cnt[3]  = 4'd2;
    ro_cnt[4]  = 4'd7;
    ro_cnt[5]  = 4'd6;

    reset     = 1'b1;
    start     = 1'b0;
    challenge = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_resp", 64'(response), 64'd0);
    check_eq("rst_sel", 64'({sel1, sel0}), 64'd0);
    check_eq("rst_clr", 64'(cnt_clr), 64'd1);
    check_eq("rst_en", 64'(cnt_en), 64'd0);
    reset = 1'b0;

    run_chal("all_12_8",   CH_ALL,   8'hFF, 1'b0, 8'h00, 0);
    run_chal("pair3_rev",  CH_P3,    8'hF7, 1'b0, 8'h00, 0);
    run_chal("pair0_tie",  CH_P0TIE, 8'hFE, 1'b1, 8'h01, 0);
    run_chal("pair7_rev",  CH_P7,    8'h7F, 1'b0, 8'h00, 0);
    run_chal("start_busy", CH_ALL,   8'hFF, 1'b0, 8'h00, 100);

    // Reset in the middle of pair 4's counting window.
    @(negedge clk);
    start     = 1'b1;
    challenge = CH_ALL;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    challenge = '0;
    repeat (300) @(negedge clk);
    check_eq("pre_rst_resp", 64'(response), 64'h0F);
    check_eq("pre_rst_en", 64'(cnt_en), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_resp", 64'(response), 64'd0);
    check_eq("arst_clr", 64'(cnt_clr), 64'd1);
    check_eq("arst_en", 64'(cnt_en), 64'd0);
    @(negedge clk);
    check_eq("arst_hold_busy", 64'(busy), 64'd0);
    check_eq("arst_hold_done", 64'(done), 64'd0);
    reset = 1'b0;
    $display("run mid_reset resp=%0h busy=%0b", response, busy);

    run_chal("after_reset", CH_ALL, 8'hFF, 1'b0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
